// File: rtl/ir_queue_pkg.sv
// ---------------------------------------------------------------------------
// ir_queue_pkg
// Project defaults and helper types shared by the instruction queue.
//   IR_WIDTH / PC_WIDTH / IRQ_DEPTH : default word width, PC tag width and queue depth
//   q_op_e                          : per-cycle queue operation {push, pop}
//   ptr_w()                         : pointer width for a given depth (at least 1 bit)
// ---------------------------------------------------------------------------
package ir_queue_pkg;

    localparam int IR_WIDTH  = 32;
    localparam int PC_WIDTH  = 32;
    localparam int IRQ_DEPTH = 4;

    // Encoding matches {push, pop} so the handshake bits cast directly.
    typedef enum logic [1:0] {
        OP_HOLD = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    // A depth-1 queue still needs a 1-bit pointer to keep port widths legal.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/ir_queue_mem.sv
// ---------------------------------------------------------------------------
// ir_queue_mem
// DEPTH x ENTRY_W register array holding {PC tag, instruction word} entries.
// One synchronous write port, one asynchronous read port, no reset.
// Ports:
//   i_clk    in  1        clock
//   i_we     in  1        write enable
//   i_waddr  in  ADDR_W   write address
//   i_wdata  in  ENTRY_W  write data
//   i_raddr  in  ADDR_W   read address
//   o_rdata  out ENTRY_W  entry at i_raddr (combinational)
// ---------------------------------------------------------------------------
module ir_queue_mem
    import ir_queue_pkg::*;
#(
    parameter  int ENTRY_W = 64,
    parameter  int DEPTH   = 4,
    localparam int ADDR_W  = ptr_w(DEPTH)
) (
    input  logic               i_clk,
    input  logic               i_we,
    input  logic [ADDR_W-1:0]  i_waddr,
    input  logic [ENTRY_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0]  i_raddr,
    output logic [ENTRY_W-1:0] o_rdata
);

    if (DEPTH == 1) begin : g_single
        // Single entry: the address carries no information.
        logic [ENTRY_W-1:0] r_entry;
        logic               w_unused_addr;

        assign w_unused_addr = ^{i_waddr, i_raddr};

        always_ff @(posedge i_clk) begin
            if (i_we) r_entry <= i_wdata;
        end

        assign o_rdata = r_entry;
    end else begin : g_array
        logic [ENTRY_W-1:0] r_mem [DEPTH];

        always_ff @(posedge i_clk) begin
            if (i_we) r_mem[i_waddr] <= i_wdata;
        end

        assign o_rdata = r_mem[i_raddr];
    end

endmodule

// File: rtl/ir_queue.sv
// ---------------------------------------------------------------------------
// ir_queue
// DEPTH-entry instruction queue between instruction memory and decode.
// Stores fetched words with their PC tag, valid/ready on both sides,
// single-cycle flush. DEPTH=1 behaves as an instruction register.
// Ports:
//   CLK_I       in   1      clock, rising edge
//   Reset_I     in   1      synchronous reset, active low
//   MemData_I   in   WIDTH  fetched instruction word
//   PC_I        in   TAG_W  PC of MemData_I
//   MemValid_I  in   1      fetch side presents a word
//   MemReady_O  out  1      queue not full
//   Flush_I     in   1      discard all entries
//   IR_O        out  WIDTH  head instruction, 0 when empty
//   PC_O        out  TAG_W  head PC tag, 0 when empty
//   IRValid_O   out  1      queue not empty
//   IRReady_I   in   1      decode consumes head
//   Count_O     out  CNT_W  occupancy 0..DEPTH
// ---------------------------------------------------------------------------
module ir_queue
    import ir_queue_pkg::*;
#(
    parameter  int WIDTH = IR_WIDTH,
    parameter  int TAG_W = PC_WIDTH,
    parameter  int DEPTH = IRQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             CLK_I,
    input  logic             Reset_I,
    input  logic [WIDTH-1:0] MemData_I,
    input  logic [TAG_W-1:0] PC_I,
    input  logic             MemValid_I,
    output logic             MemReady_O,
    input  logic             Flush_I,
    output logic [WIDTH-1:0] IR_O,
    output logic [TAG_W-1:0] PC_O,
    output logic             IRValid_O,
    input  logic             IRReady_I,
    output logic [CNT_W-1:0] Count_O
);

    localparam int               PTR_W    = ptr_w(DEPTH);
    localparam int               ENTRY_W  = TAG_W + WIDTH;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_empty;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    q_op_e              w_op;
    logic [ENTRY_W-1:0] w_rd_entry;

    // Power-of-two depth wraps naturally; depth 1 pins the pointer at 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (DEPTH == 1) return '0;
        else            return p + 1'b1;
    endfunction

    // Handshakes use registered state only, so MemReady_O never sees IRReady_I.
    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == FULL_CNT);
    assign w_push  = MemValid_I & ~w_full  & ~Flush_I;
    assign w_pop   = IRReady_I  & ~w_empty & ~Flush_I;
    assign w_op    = q_op_e'({w_push, w_pop});

    always_ff @(posedge CLK_I) begin
        if (!Reset_I || Flush_I) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            case (w_op)
                OP_PUSH: r_count <= r_count + 1'b1;
                OP_POP:  r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    ir_queue_mem #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_mem (
        .i_clk   (CLK_I),
        .i_we    (w_push),
        .i_waddr (r_wr_ptr),
        .i_wdata ({PC_I, MemData_I}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_entry)
    );

    // Explicit zero when empty so stale or uninitialised storage never leaks out.
    assign IR_O       = w_empty ? '0 : w_rd_entry[WIDTH-1:0];
    assign PC_O       = w_empty ? '0 : w_rd_entry[ENTRY_W-1:WIDTH];
    assign IRValid_O  = ~w_empty;
    assign MemReady_O = ~w_full;
    assign Count_O    = r_count;

endmodule
